reflet_mem_bridge: RTL and testbench
====================================

# reflet_mem_bridge

Memory-side bridge between the Reflet CPU's external RAM port (`addr`, `data_out`, `data_in`, `write_en`) and a variable-latency req/ack memory bus. Every new read address or pending write becomes a bus transaction. The CPU's `enable` is held low until the transaction completes, so the fixed-latency RAM assumption of the address unit holds even with slow memories. A one-entry read cache (last address/data) lets repeated reads of the same word proceed at full speed.

## Interface
Parameters:
- `wordsize`, 16, width of address and data buses.
- `timeout_cycles`, 255, maximum cycles waited for `ext_ack` (used only with the timeout feature).

Ports (one clock `clk`; `reset` is asynchronous and active-low):
- `clk` in 1: clock.
- `reset` in 1: asynchronous active-low reset.
- `cpu_addr` in wordsize: CPU RAM address.
- `cpu_data_out` in wordsize: CPU write data.
- `cpu_write_en` in 1: CPU write request, held until serviced.
- `cpu_data_in` out wordsize: registered read data to the CPU.
- `cpu_enable` out 1: CPU enable; low = stall.
- `ext_addr` out wordsize: bus address, registered.
- `ext_wdata` out wordsize: bus write data, registered.
- `ext_we` out 1: bus write qualifier, valid with `ext_req`.
- `ext_req` out 1: bus request, registered.
- `ext_rdata` in wordsize: bus read data, valid with `ext_ack`.
- `ext_ack` in 1: single-cycle completion pulse.
- `bus_error` out 1: sticky timeout flag.

## Operation
- State machine, three states:
  - IDLE: no transaction. A miss moves to REQ.
  - REQ: waiting for the bus. `ext_ack` moves to DONE.
  - DONE: one cycle. Then returns to IDLE.
- Cache: `c_valid`, `c_addr`. The cached data is `cpu_data_in` itself.
- `wr_done` flag: set when a write completes; cleared when `cpu_write_en` is low or `cpu_addr != c_addr`.
- Miss condition: `cpu_write_en ? !wr_done : (!c_valid || cpu_addr != c_addr)`. This is combinational.
- `cpu_enable = (state==IDLE) && !miss`. This is combinational. Stall begins in the cycle the miss appears.
- IDLE with a miss, at the clock edge:
  - latch `ext_addr<=cpu_addr`, `ext_wdata<=cpu_data_out`, `ext_we<=cpu_write_en`;
  - set `ext_req<=1`;
  - go to REQ.
- REQ: `ext_req`, `ext_addr`, `ext_we` and `ext_wdata` stay stable until `ext_ack`. On `ext_ack`:
  - drop `ext_req`;
  - for a read: `cpu_data_in<=ext_rdata`, `c_addr<=ext_addr`, `c_valid<=1`;
  - for a write: `wr_done<=1`. If `ext_addr==c_addr`, also `cpu_data_in<=ext_wdata` (write-through update); otherwise the cache is unchanged;
  - go to DONE.
- DONE → IDLE unconditionally. The next IDLE cycle hits, so `cpu_enable` goes high for that cycle.
- `ext_ack` outside REQ is ignored.
- An address change during a stall is not possible, because the CPU is frozen. Any change seen in IDLE is simply a new miss.
- Reset values: state IDLE, `c_valid=0`, `wr_done=0`, `cpu_data_in=0`, `ext_req=0`, `ext_we=0`, `ext_addr=0`, `ext_wdata=0`, `bus_error=0`.
- Reset mid-transaction: `ext_req` drops asynchronously. A later `ext_ack` is ignored, and the cache is invalid.

## Timing
- Hit: zero added latency; `cpu_enable=1`.
- Miss, with ack arriving k cycles after `ext_req` rises (k≥0 cycles in REQ before the ack is sampled): `cpu_enable` is low for k+3 cycles, covering IDLE, REQ×(k+1) and DONE.
- With ack in the first REQ cycle, the stall is 3 cycles.
- `cpu_data_in` is valid from the DONE cycle onward and holds until the next read completion.

## Configuration
- `REFLET_MEM_BRIDGE_TIMEOUT_EN` defined:
  - a counter runs in REQ;
  - after `timeout_cycles` cycles without `ext_ack`: drop `ext_req`, set `bus_error`, force `cpu_data_in<=all ones` for a read (`c_valid` stays 0), set `wr_done<=1` for a write, then go to DONE;
  - `bus_error` is sticky until reset.
- Undefined:
  - REQ waits indefinitely;
  - `bus_error` is tied to 0;
  - no counter logic is present.

## Structure
- State encodings `BRIDGE_IDLE`/`BRIDGE_REQ`/`BRIDGE_DONE` go as defines in shared `reflet.vh`.
- The timeout counter is the natural sub-module: `reflet_bridge_watchdog`.
  - Inputs: clk, reset, run, clear.
  - Output: expired pulse.
  - Parameter: `timeout_cycles`.

## Test plan
- Read `cpu_addr=0x0010`, ack after 2 cycles with `ext_rdata=0xBEEF` → `cpu_enable` low 5 cycles; `cpu_data_in=0xBEEF`; a repeat read of 0x0010 gives no `ext_req`.
- Write 0x1234 to cached 0x0010, then read 0x0010 → one bus write with `ext_we=1`, `ext_wdata=0x1234`; the read hits with `cpu_data_in=0x1234`, no bus read.
- Write held high for 3 cycles after completion at the same address → exactly one `ext_req` pulse.
- Reset asserted in REQ, then ack → `ext_req=0` immediately; ack ignored; the next read of the same address misses.
- Spurious `ext_ack` while IDLE → no state or data change.
- Timeout enabled, `timeout_cycles=4`, no ack → `ext_req` drops after 4 REQ cycles; `bus_error=1`; `cpu_data_in=0xFFFF`; the CPU resumes.

Source files
------------

// File: rtl/reflet_mem_bridge_pkg.sv
// Shared types for the Reflet memory bridge: bridge FSM state encoding.
package reflet_mem_bridge_pkg;

   typedef enum logic [1:0] {
      BRIDGE_IDLE = 2'd0,
      BRIDGE_REQ  = 2'd1,
      BRIDGE_DONE = 2'd2
   } bridge_state_t;

endpackage

// File: rtl/reflet_bridge_watchdog.sv
// REQ-phase timeout counter for the memory bridge; only built when
// REFLET_MEM_BRIDGE_TIMEOUT_EN is defined, so the default build carries no counter.
`ifdef REFLET_MEM_BRIDGE_TIMEOUT_EN
module reflet_bridge_watchdog #(
   parameter int timeout_cycles = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic expired
);

   localparam int CW = $clog2(timeout_cycles + 1);

   logic [CW-1:0] cnt;

   // expired fires in the timeout_cycles-th consecutive run cycle
   assign expired = run && (cnt == CW'(timeout_cycles - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                cnt <= '0;
      else if (clear)            cnt <= '0;
      else if (run && !expired)  cnt <= cnt + 1'b1;
   end

endmodule
`endif

// File: rtl/reflet_mem_bridge.sv
// Reflet CPU RAM port to req/ack bus bridge with one-entry read cache.
// Optional REQ timeout with sticky bus_error: define REFLET_MEM_BRIDGE_TIMEOUT_EN.
module reflet_mem_bridge
   import reflet_mem_bridge_pkg::*;
#(
   parameter int wordsize       = 16,
   parameter int timeout_cycles = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [wordsize-1:0] cpu_addr,
   input  logic [wordsize-1:0] cpu_data_out,
   input  logic                cpu_write_en,
   output logic [wordsize-1:0] cpu_data_in,
   output logic                cpu_enable,
   output logic [wordsize-1:0] ext_addr,
   output logic [wordsize-1:0] ext_wdata,
   output logic                ext_we,
   output logic                ext_req,
   input  logic [wordsize-1:0] ext_rdata,
   input  logic                ext_ack,
   output logic                bus_error
);

   bridge_state_t       state, nxt;
   logic                c_valid, wr_done, miss, expired;
   logic [wordsize-1:0] c_addr;

   // wr_done only covers the word just written; a held write_en moving to a
   // new address must miss in that same cycle, not one cycle later
   assign miss = cpu_write_en ? !(wr_done && cpu_addr == ext_addr)
                              : (!c_valid || cpu_addr != c_addr);

`ifdef REFLET_MEM_BRIDGE_TIMEOUT_EN
   logic wd_run, wd_clear;
   assign wd_run   = (state == BRIDGE_REQ) && !ext_ack;
   assign wd_clear = (state != BRIDGE_REQ);

   reflet_bridge_watchdog #(.timeout_cycles(timeout_cycles)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .run     (wd_run),
      .clear   (wd_clear),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       bus_error <= 1'b0;
      else if (expired) bus_error <= 1'b1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (timeout_cycles == 0);
   assign expired   = 1'b0;
   assign bus_error = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= BRIDGE_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         BRIDGE_IDLE: if (miss) nxt = BRIDGE_REQ;
         BRIDGE_REQ:  if (ext_ack || expired) nxt = BRIDGE_DONE;
         BRIDGE_DONE: nxt = BRIDGE_IDLE;
         default:     nxt = BRIDGE_IDLE;
      endcase
   end

   always_comb begin
      cpu_enable = (state == BRIDGE_IDLE) && !miss;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         c_valid     <= 1'b0;
         c_addr      <= '0;
         wr_done     <= 1'b0;
         cpu_data_in <= '0;
         ext_req     <= 1'b0;
         ext_we      <= 1'b0;
         ext_addr    <= '0;
         ext_wdata   <= '0;
      end else begin
         if (!cpu_write_en || cpu_addr != ext_addr) wr_done <= 1'b0;
         case (state)
            BRIDGE_IDLE: if (miss) begin
               ext_addr  <= cpu_addr;
               ext_wdata <= cpu_data_out;
               ext_we    <= cpu_write_en;
               ext_req   <= 1'b1;
            end
            BRIDGE_REQ: if (ext_ack) begin
               ext_req <= 1'b0;
               if (ext_we) begin
                  wr_done <= 1'b1;
                  if (ext_addr == c_addr) cpu_data_in <= ext_wdata;
               end else begin
                  cpu_data_in <= ext_rdata;
                  c_addr      <= ext_addr;
                  c_valid     <= 1'b1;
               end
            end else if (expired) begin
               // failed read returns all ones and must not satisfy a later read
               ext_req <= 1'b0;
               if (ext_we) wr_done <= 1'b1;
               else begin
                  cpu_data_in <= '1;
                  c_valid     <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reflet_mem_bridge.sv
// Self-checking bench for reflet_mem_bridge: bus-transaction scoreboard plus
// per-scenario stall and data checks.
module tb_reflet_mem_bridge;

   localparam int W   = 16;
   localparam int TMO = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] cpu_addr, cpu_data_out, cpu_data_in, ext_addr, ext_wdata, ext_rdata;
   logic         cpu_write_en, cpu_enable, ext_we, ext_req, ext_ack, bus_error;

   always #5 clk = ~clk;

   reflet_mem_bridge #(.wordsize(W), .timeout_cycles(TMO)) dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_addr     (cpu_addr),
      .cpu_data_out (cpu_data_out),
      .cpu_write_en (cpu_write_en),
      .cpu_data_in  (cpu_data_in),
      .cpu_enable   (cpu_enable),
      .ext_addr     (ext_addr),
      .ext_wdata    (ext_wdata),
      .ext_we       (ext_we),
      .ext_req      (ext_req),
      .ext_rdata    (ext_rdata),
      .ext_ack      (ext_ack),
      .bus_error    (bus_error)
   );

   typedef struct packed {
      logic         we;
      logic [W-1:0] addr;
      logic [W-1:0] wdata;
   } bus_t;

   bus_t exp_q[$];
   int   tests = 0, fails = 0, req_rises = 0;
   logic req_d = 1'b0;

   // scoreboard: every rising ext_req must match the oldest expected transaction
   always @(negedge clk) begin
      bus_t e;
      if (ext_req === 1'b1 && req_d !== 1'b1) begin
         req_rises++;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL bus_unexpected: got addr=%h we=%b, required no request", ext_addr, ext_we);
         end else begin
            e = exp_q.pop_front();
            if (ext_addr !== e.addr || ext_we !== e.we || (e.we && ext_wdata !== e.wdata)) begin
               fails++;
               $display("FAIL bus_txn: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                        ext_addr, ext_we, ext_wdata, e.addr, e.we, e.wdata);
            end
         end
      end
      req_d = ext_req;
   end

   task automatic expect_txn(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wdata);
      bus_t e;
      e.we = we; e.addr = addr; e.wdata = wdata;
      exp_q.push_back(e);
   endtask

   // acks the k-th REQ cycle (k<0: never), counts stall cycles until cpu_enable
   task automatic service(input int k, input logic [W-1:0] rdata, input int exp_stall, input string name);
      int stall, reqc;
      bit done;
      stall = 0; reqc = 0; done = 0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(negedge clk);
         ext_ack = 1'b0;
         if (cpu_enable === 1'b1) done = 1;
         else begin
            stall++;
            if (ext_req === 1'b1) begin
               if (reqc == k) begin ext_ack = 1'b1; ext_rdata = rdata; end
               reqc++;
            end
         end
      end
      ext_ack = 1'b0;
      tests++;
      if (!done || stall != exp_stall) begin
         fails++;
         $display("FAIL %s_stall: got %0d cycles (resumed=%0b), required %0d", name, stall, done, exp_stall);
      end
   endtask

   task automatic xact(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                       input logic [W-1:0] rdata, input int k, input int exp_stall, input string name);
      @(posedge clk); #1;
      cpu_write_en = we; cpu_addr = addr; cpu_data_out = wdata;
      if (exp_stall > 0) expect_txn(we, addr, wdata);
      service(k, rdata, exp_stall, name);
   endtask

   task automatic check_data(input logic [W-1:0] exp, input string name);
      tests++;
      if (cpu_data_in !== exp) begin
         fails++;
         $display("FAIL %s_data: got %h, required %h", name, cpu_data_in, exp);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; cpu_addr = '0; cpu_data_out = '0; cpu_write_en = 1'b0;
      ext_ack = 1'b0; ext_rdata = '0;
      repeat (2) @(negedge clk);
      tests++;
      if ({ext_req, ext_we, ext_addr, ext_wdata, cpu_data_in, bus_error, cpu_enable} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h data=%h err=%b en=%b, required all zero",
                  ext_req, ext_we, ext_addr, ext_wdata, cpu_data_in, bus_error, cpu_enable);
      end
      // cache is invalid, so the idle read of address 0 misses right after release
      expect_txn(1'b0, 16'h0000, 16'h0000);
      @(posedge clk); #1 reset = 1'b1;
      service(0, 16'h0042, 3, "post_reset_read");
      check_data(16'h0042, "post_reset_read");
   endtask

   task automatic test_read_miss_hit;
      int r0;
      xact(1'b0, 16'h0010, 16'h0, 16'hBEEF, 2, 5, "read_miss");
      check_data(16'hBEEF, "read_miss");
      r0 = req_rises;
      xact(1'b0, 16'h0010, 16'h0, 16'h0BAD, 0, 0, "read_hit");
      check_data(16'hBEEF, "read_hit");
      tests++;
      if (req_rises != r0) begin
         fails++;
         $display("FAIL read_hit_no_req: got %0d requests, required 0", req_rises - r0);
      end
   endtask

   task automatic test_write_through;
      int r0;
      xact(1'b1, 16'h0010, 16'h1234, 16'h0, 0, 3, "write");
      r0 = req_rises;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (cpu_enable !== 1'b1) begin
            fails++;
            $display("FAIL write_hold_enable: got %b at hold cycle %0d, required 1", cpu_enable, i);
         end
      end
      xact(1'b0, 16'h0010, 16'h0, 16'h0BAD, 0, 0, "read_after_write");
      check_data(16'h1234, "read_after_write");
      tests++;
      if (req_rises != r0) begin
         fails++;
         $display("FAIL write_single_req: got %0d extra requests, required 0", req_rises - r0);
      end
   endtask

   task automatic test_spurious_ack;
      xact(1'b0, 16'h0020, 16'h0, 16'h5555, 1, 4, "read_k1");
      check_data(16'h5555, "read_k1");
      @(negedge clk); ext_ack = 1'b1; ext_rdata = 16'hAAAA;
      @(negedge clk); ext_ack = 1'b0;
      tests++;
      if (cpu_data_in !== 16'h5555 || ext_req !== 1'b0 || cpu_enable !== 1'b1) begin
         fails++;
         $display("FAIL spurious_ack: got data=%h req=%b en=%b, required data=5555 req=0 en=1",
                  cpu_data_in, ext_req, cpu_enable);
      end
      xact(1'b0, 16'h0020, 16'h0, 16'h0BAD, 0, 0, "spurious_rehit");
      check_data(16'h5555, "spurious_rehit");
   endtask

   task automatic test_reset_mid_req;
      @(posedge clk); #1;
      cpu_write_en = 1'b0; cpu_addr = 16'h0030;
      expect_txn(1'b0, 16'h0030, 16'h0);
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (ext_req !== 1'b1) begin
         fails++;
         $display("FAIL mid_req_setup: got ext_req=%b, required 1", ext_req);
      end
      #2 reset = 1'b0;
      #1;
      tests++;
      if (ext_req !== 1'b0) begin
         fails++;
         $display("FAIL reset_async_req: got ext_req=%b, required 0", ext_req);
      end
      @(negedge clk); ext_ack = 1'b1; ext_rdata = 16'h7777;
      @(negedge clk); ext_ack = 1'b0;
      check_data(16'h0000, "reset_ack_ignored");
      // same address must miss again once reset is released
      expect_txn(1'b0, 16'h0030, 16'h0);
      @(posedge clk); #1 reset = 1'b1;
      service(1, 16'h3030, 4, "reread_after_reset");
      check_data(16'h3030, "reread_after_reset");
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] d, a;
      int k;
      for (int i = 0; i < 5; i++) begin
         a = W'(16'h0100 + 2 * i);
         d = W'($urandom);
         k = $urandom_range(0, 2);
         xact(1'b0, a, 16'h0, d, k, k + 3, "b2b_read");
         check_data(d, "b2b_read");
      end
      // write to an uncached word leaves the cached line untouched
      xact(1'b1, 16'h0200, 16'hC0DE, 16'h0, 1, 4, "b2b_write_uncached");
      check_data(d, "b2b_write_uncached");
      xact(1'b0, a, 16'h0, 16'h0BAD, 0, 0, "b2b_rehit");
      check_data(d, "b2b_rehit");
   endtask

   task automatic test_timeout;
`ifdef REFLET_MEM_BRIDGE_TIMEOUT_EN
      xact(1'b0, 16'h0040, 16'h0, 16'h0, -1, TMO + 2, "timeout_read");
      check_data(16'hFFFF, "timeout_read");
      tests++;
      if (bus_error !== 1'b1 || ext_req !== 1'b0) begin
         fails++;
         $display("FAIL timeout_flags: got err=%b req=%b, required err=1 req=0", bus_error, ext_req);
      end
      xact(1'b0, 16'h0040, 16'h0, 16'h4040, 0, 3, "timeout_retry");
      check_data(16'h4040, "timeout_retry");
      tests++;
      if (bus_error !== 1'b1) begin
         fails++;
         $display("FAIL timeout_sticky: got err=%b, required 1", bus_error);
      end
`else
      tests++;
      if (bus_error !== 1'b0) begin
         fails++;
         $display("FAIL bus_error_tied: got %b, required 0", bus_error);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_read_miss_hit();
      test_write_through();
      test_spurious_ack();
      test_reset_mid_req();
      test_back_to_back();
      test_timeout();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL bus_missing: got %0d expected transactions never issued, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule
